// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Byte-serial data memory access sequencer. It turns one load or store
//   request of 1/2/4/8 bytes into single-byte cycles on an 8-bit memory port.
//   It assembles load data little-endian, then sign- or zero-extends it.
//
// Configuration macro: MISALIGN_TRAP_EN
//   Undefined (default): misaligned accesses run byte-serially; err stays 0.
//   Defined: a misaligned request skips all memory cycles and completes on
//   the next cycle with done=1 and err=1. rdata is left unchanged.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      synchronous active-low reset
//   req_read   load request (sampled only in IDLE)
//   req_write  store request (wins over req_read when both are set)
//   addr       byte address of the access
//   wdata      store data; the low 8N bits are used
//   func3      [1:0] size code (N = 1 << size bytes), [2] unsigned-load flag
//   rdata      extended load result; changes only when a load completes
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   err        misalignment flag; only ever high together with done
//   mem_addr   byte address presented to memory (0 when idle)
//   mem_wdata  store byte presented to memory (0 when idle)
//   mem_we     memory write strobe
//   mem_re     memory read strobe; mem_rdata is valid the following cycle
//   mem_rdata  read byte returned by memory
//
// All outputs are registered. The next-state logic also decodes the outputs
// for the state being entered, so each output is valid for the whole cycle
// of its state.
// -----------------------------------------------------------------------------
module data_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  input  logic [2:0]  func3,
  output logic [63:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned BYTEW = 8;
  localparam int unsigned IDXW  = 3;   // byte index within an 8-byte word
  localparam int unsigned CNTW  = 4;   // holds byte counts up to 8

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_RD_ISSUE   = 3'd1,
    S_RD_CAPTURE = 3'd2,
    S_WR         = 3'd3,
    S_DONE       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [XLEN-1:0]    addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [XLEN-1:0]    asm_q, asm_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [XLEN-1:0]    mem_addr_q, mem_addr_d;
  logic [BYTEW-1:0]   mem_wdata_q, mem_wdata_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_re_q, mem_re_d;

  logic [CNTW-1:0]    nbytes_c;
  logic               last_byte_c;

  // Byte count of the latched access and whether the current byte is its last.
  assign nbytes_c    = CNTW'(1) << size_q;
  assign last_byte_c = ({1'b0, idx_q} + CNTW'(1)) >= nbytes_c;

`ifdef MISALIGN_TRAP_EN
  logic [IDXW-1:0]    req_mask_c;
  logic               misalign_c;

  // The low address bits must be zero for the requested access size.
  assign req_mask_c = IDXW'((CNTW'(1) << func3[1:0]) - CNTW'(1));
  assign misalign_c = |(addr[IDXW-1:0] & req_mask_c);
`endif

  // Extends an assembled little-endian value to 64 bits according to size/sign.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [1:0]      sz,
                                             input logic            uns);
    case (sz)
      2'd0:    extend = uns ? {56'd0, v[7:0]}  : {{56{v[7]}},  v[7:0]};
      2'd1:    extend = uns ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
      2'd2:    extend = uns ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
      default: extend = v;
    endcase
  endfunction

  // Next-state logic, then output decode for the state being entered.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_read || req_write) begin
          addr_d  = addr;
          wdata_d = wdata;
          size_d  = func3[1:0];
          uns_d   = func3[2];
          idx_d   = '0;
          asm_d   = '0;
`ifdef MISALIGN_TRAP_EN
          if (misalign_c) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = req_write ? S_WR : S_RD_ISSUE;
          end
`else
          state_d = req_write ? S_WR : S_RD_ISSUE;
`endif
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_CAPTURE;
      end
      S_RD_CAPTURE: begin
        asm_d[{idx_q, 3'b000} +: BYTEW] = mem_rdata;
        idx_d = idx_q + IDXW'(1);
        if (last_byte_c) begin
          state_d = S_DONE;
          rdata_d = extend(asm_d, size_q, uns_q);
        end else begin
          state_d = S_RD_ISSUE;
        end
      end
      S_WR: begin
        idx_d   = idx_q + IDXW'(1);
        state_d = last_byte_c ? S_DONE : S_WR;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Memory port for the next cycle; the address wraps modulo 2^64.
    case (state_d)
      S_RD_ISSUE: begin
        mem_re_d   = 1'b1;
        mem_addr_d = addr_d + XLEN'(idx_d);
      end
      S_WR: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_d + XLEN'(idx_d);
        mem_wdata_d = wdata_d[{idx_d, 3'b000} +: BYTEW];
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      idx_q       <= '0;
      asm_q       <= '0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Directed bench for data_mem_ctrl with a 1 KiB byte memory model
//   (address bits [9:0]) that reads with one cycle of latency.
// -----------------------------------------------------------------------------
module tb_data_mem_ctrl;

  logic        clk;
  logic        reset;
  logic        req_read;
  logic        req_write;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [2:0]  func3;
  logic [63:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [0:1023];
  int          re_cnt = 0;
  int          we_cnt = 0;
  int          both_cnt = 0;
  int          errnd_cnt = 0;
  int          idle_bad = 0;
  logic [63:0] last_we_addr = '0;

  data_mem_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write),
    .addr      (addr),
    .wdata     (wdata),
    .func3     (func3),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model plus protocol monitors.
  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr[9:0]] <= mem_wdata;
      last_we_addr       <= mem_addr;
      we_cnt             <= we_cnt + 1;
    end
    if (mem_re === 1'b1) begin
      mem_rdata <= mem[mem_addr[9:0]];
      re_cnt    <= re_cnt + 1;
    end
    if (mem_re === 1'b1 && mem_we === 1'b1) both_cnt <= both_cnt + 1;
    if (err === 1'b1 && done !== 1'b1) errnd_cnt <= errnd_cnt + 1;
    if (busy === 1'b0 && (mem_addr !== 64'd0 || mem_wdata !== 8'd0 ||
                          mem_we !== 1'b0 || mem_re !== 1'b0))
      idle_bad <= idle_bad + 1;
  end

  // Runs one request from IDLE. lat counts cycles from the accept edge to done.
  // The task returns in the cycle after done, with done_after/busy_after sampled there.
  task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic [2:0] f3, input bit disturb,
                        output int lat, output logic err_seen, output logic [63:0] rd_seen,
                        output logic done_after, output logic busy_after,
                        output int re_d, output int we_d);
    int re0, we0;
    re0 = re_cnt;
    we0 = we_cnt;
    req_read = rd; req_write = wr; addr = a; wdata = wd; func3 = f3;
    @(posedge clk); #1;
    req_read = 1'b0; req_write = 1'b0;
    if (disturb) begin
      req_read = 1'b1; req_write = 1'b1;
      addr = 64'h3F0; wdata = '1; func3 = 3'b011;
    end
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    err_seen = err;
    rd_seen  = rdata;
    req_read = 1'b0; req_write = 1'b0;
    addr = '0; wdata = '0; func3 = '0;
    @(posedge clk); #1;
    done_after = done;
    busy_after = busy;
    re_d = re_cnt - re0;
    we_d = we_cnt - we0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_read = 1'b0; req_write = 1'b0;
    addr = '0; wdata = '0; func3 = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_cmp++; if ({busy, done, err, mem_we, mem_re} !== 5'b0) begin n_bad++;
      $display("FAIL reset_ctl: got %b want 00000", {busy, done, err, mem_we, mem_re}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== 72'd0) begin n_bad++;
      $display("FAIL reset_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_store_sd();
    int lat, re_d, we_d; logic e, da, ba; logic [63:0] r;
    access(1'b0, 1'b1, 64'h100, 64'h1122334455667788, 3'b011, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (lat !== 9) begin n_bad++; $display("FAIL sd_latency: got %0d want 9", lat); end
    n_cmp++; if ({mem[263], mem[262], mem[261], mem[260], mem[259], mem[258], mem[257], mem[256]}
                 !== 64'h1122334455667788) begin n_bad++;
      $display("FAIL sd_bytes: got %h want 1122334455667788",
               {mem[263], mem[262], mem[261], mem[260], mem[259], mem[258], mem[257], mem[256]}); end
    n_cmp++; if (we_d !== 8 || re_d !== 0) begin n_bad++;
      $display("FAIL sd_strobes: got we=%0d re=%0d want 8/0", we_d, re_d); end
    n_cmp++; if ({e, da, ba} !== 3'b000) begin n_bad++;
      $display("FAIL sd_pulse: got err/done_after/busy_after=%b want 000", {e, da, ba}); end
    n_cmp++; if (r !== 64'd0) begin n_bad++; $display("FAIL sd_rdata_kept: got %h want 0", r); end
  endtask

  task automatic test_load_byte();
    int lat, re_d, we_d; logic e, da, ba; logic [63:0] r;
    access(1'b0, 1'b1, 64'h100, 64'h80, 3'b000, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (lat !== 2 || mem[256] !== 8'h80) begin n_bad++;
      $display("FAIL sb: got lat=%0d byte=%h want 2/80", lat, mem[256]); end
    access(1'b1, 1'b0, 64'h100, 64'h0, 3'b000, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'hFFFFFFFFFFFFFF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffffffffffff80", r); end
    n_cmp++; if (lat !== 3 || re_d !== 1 || we_d !== 0) begin n_bad++;
      $display("FAIL lb_timing: got lat=%0d re=%0d we=%0d want 3/1/0", lat, re_d, we_d); end
    access(1'b1, 1'b0, 64'h100, 64'h0, 3'b100, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'h80 || lat !== 3) begin n_bad++;
      $display("FAIL lbu: got %h lat=%0d want 80/3", r, lat); end
  endtask

  task automatic test_load_word();
    int lat, re_d, we_d; logic e, da, ba; logic [63:0] r;
    access(1'b0, 1'b1, 64'h104, 64'h84030201, 3'b010, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL sw_latency: got %0d want 5", lat); end
    // Conflicting requests are driven throughout this load and must be ignored.
    access(1'b1, 1'b0, 64'h104, 64'h0, 3'b010, 1'b1, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'hFFFFFFFF84030201) begin n_bad++; $display("FAIL lw_rdata: got %h want ffffffff84030201", r); end
    n_cmp++; if (lat !== 9 || re_d !== 4 || we_d !== 0) begin n_bad++;
      $display("FAIL lw_timing: got lat=%0d re=%0d we=%0d want 9/4/0", lat, re_d, we_d); end
    n_cmp++; if ({da, ba} !== 2'b00) begin n_bad++; $display("FAIL lw_pulse: got %b want 00", {da, ba}); end
    access(1'b1, 1'b0, 64'h104, 64'h0, 3'b110, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'h0000000084030201) begin n_bad++; $display("FAIL lwu: got %h want 0000000084030201", r); end
    access(1'b1, 1'b0, 64'h100, 64'h0, 3'b011, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'h8403020155667780 || lat !== 17) begin n_bad++;
      $display("FAIL ld: got %h lat=%0d want 8403020155667780/17", r, lat); end
    access(1'b1, 1'b0, 64'h106, 64'h0, 3'b001, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'hFFFFFFFFFFFF8403 || lat !== 5) begin n_bad++;
      $display("FAIL lh: got %h lat=%0d want ffffffffffff8403/5", r, lat); end
    access(1'b1, 1'b0, 64'h106, 64'h0, 3'b101, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'h8403) begin n_bad++; $display("FAIL lhu: got %h want 8403", r); end
  endtask

  task automatic test_both_req();
    int lat, re_d, we_d; logic e, da, ba; logic [63:0] r;
    access(1'b1, 1'b1, 64'h10, 64'hBEEF, 3'b001, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if ({mem[17], mem[16]} !== 16'hBEEF) begin n_bad++;
      $display("FAIL both_bytes: got %h want beef", {mem[17], mem[16]}); end
    n_cmp++; if (r !== 64'h8403 || re_d !== 0 || we_d !== 2 || lat !== 3) begin n_bad++;
      $display("FAIL both_ctl: got rdata=%h re=%0d we=%0d lat=%0d want 8403/0/2/3", r, re_d, we_d, lat); end
  endtask

  task automatic test_misalign();
    int lat, re_d, we_d; logic e, da, ba; logic [63:0] r;
    access(1'b0, 1'b1, 64'h102, 64'hA1B2C3D4, 3'b010, 1'b0, lat, e, r, da, ba, re_d, we_d);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (lat !== 1 || e !== 1'b1 || we_d !== 0) begin n_bad++;
      $display("FAIL sw_trap: got lat=%0d err=%b we=%0d want 1/1/0", lat, e, we_d); end
    n_cmp++; if ({mem[261], mem[260], mem[259], mem[258]} !== 32'h02015566 || r !== 64'h8403) begin n_bad++;
      $display("FAIL sw_trap_state: got mem=%h rdata=%h want 02015566/8403",
               {mem[261], mem[260], mem[259], mem[258]}, r); end
    access(1'b1, 1'b0, 64'h102, 64'h0, 3'b010, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (lat !== 1 || e !== 1'b1 || re_d !== 0 || r !== 64'h8403) begin n_bad++;
      $display("FAIL lw_trap: got lat=%0d err=%b re=%0d rdata=%h want 1/1/0/8403", lat, e, re_d, r); end
    access(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h5AA5, 3'b001, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (lat !== 1 || e !== 1'b1 || we_d !== 0) begin n_bad++;
      $display("FAIL sh_wrap_trap: got lat=%0d err=%b we=%0d want 1/1/0", lat, e, we_d); end
`else
    n_cmp++; if (lat !== 5 || e !== 1'b0 || we_d !== 4) begin n_bad++;
      $display("FAIL sw_misalign: got lat=%0d err=%b we=%0d want 5/0/4", lat, e, we_d); end
    n_cmp++; if ({mem[261], mem[260], mem[259], mem[258]} !== 32'hA1B2C3D4) begin n_bad++;
      $display("FAIL sw_misalign_bytes: got %h want a1b2c3d4", {mem[261], mem[260], mem[259], mem[258]}); end
    access(1'b1, 1'b0, 64'h102, 64'h0, 3'b010, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'hFFFFFFFFA1B2C3D4 || e !== 1'b0) begin n_bad++;
      $display("FAIL lw_misalign: got %h err=%b want ffffffffa1b2c3d4/0", r, e); end
    access(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h5AA5, 3'b001, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (mem[1023] !== 8'hA5 || mem[0] !== 8'h5A || last_we_addr !== 64'd0) begin n_bad++;
      $display("FAIL sh_wrap: got hi=%h lo=%h last_addr=%h want a5/5a/0", mem[1023], mem[0], last_we_addr); end
`endif
  endtask

  task automatic test_reset_mid_store();
    int lat, re_d, we_d, we0, dcnt; logic e, da, ba; logic [63:0] r;
    access(1'b0, 1'b1, 64'h200, 64'h0, 3'b011, 1'b0, lat, e, r, da, ba, re_d, we_d);
    we0 = we_cnt;
    req_write = 1'b1; addr = 64'h200; wdata = 64'h1122334455667788; func3 = 3'b011;
    @(posedge clk); #1;                 // first WR cycle
    req_write = 1'b0; addr = '0; wdata = '0; func3 = '0;
    @(posedge clk); #1;                 // second WR cycle
    reset = 1'b0;
    @(posedge clk); #1;                 // third WR cycle is cut off here
    n_cmp++; if ({busy, done, err, mem_we, mem_re} !== 5'b0 || mem_addr !== 64'd0 ||
                 mem_wdata !== 8'd0 || rdata !== 64'd0) begin n_bad++;
      $display("FAIL midreset_outputs: got ctl=%b addr=%h wd=%h rdata=%h want 0",
               {busy, done, err, mem_we, mem_re}, mem_addr, mem_wdata, rdata); end
    reset = 1'b1;
    dcnt = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    n_cmp++; if (dcnt !== 0 || busy !== 1'b0) begin n_bad++;
      $display("FAIL midreset_nodone: got done_pulses=%0d busy=%b want 0/0", dcnt, busy); end
    n_cmp++; if ({mem[519], mem[518], mem[517], mem[516], mem[515], mem[514], mem[513], mem[512]}
                 !== 64'h0000000000007788 || (we_cnt - we0) !== 2) begin n_bad++;
      $display("FAIL midreset_bytes: got %h we=%0d want 0000000000007788/2",
               {mem[519], mem[518], mem[517], mem[516], mem[515], mem[514], mem[513], mem[512]}, we_cnt - we0); end
  endtask

  task automatic test_back_to_back();
    int lat, re_d, we_d; logic e, da, ba; logic [63:0] r;
    access(1'b0, 1'b1, 64'h300, 64'hFFFF_FFFF_FFFF_FF7F, 3'b000, 1'b0, lat, e, r, da, ba, re_d, we_d);
    access(1'b1, 1'b0, 64'h300, 64'h0, 3'b000, 1'b0, lat, e, r, da, ba, re_d, we_d);
    n_cmp++; if (r !== 64'h7F || lat !== 3 || mem[769] === 8'hFF) begin n_bad++;
      $display("FAIL b2b_lb_positive: got %h lat=%0d next=%h want 7f/3/untouched", r, lat, mem[769]); end
  endtask

  task automatic test_protocol();
    n_cmp++; if (both_cnt !== 0) begin n_bad++; $display("FAIL re_we_overlap: got %0d want 0", both_cnt); end
    n_cmp++; if (errnd_cnt !== 0) begin n_bad++; $display("FAIL err_without_done: got %0d want 0", errnd_cnt); end
    n_cmp++; if (idle_bad !== 0) begin n_bad++; $display("FAIL idle_bus_nonzero: got %0d want 0", idle_bad); end
  endtask

  initial begin
    mem_rdata = '0;
    test_reset();
    test_store_sd();
    test_load_byte();
    test_load_word();
    test_both_req();
    test_misalign();
    test_reset_mid_store();
    test_back_to_back();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
